// File: rtl/nec_ir_transmitter.sv
// NEC infrared frame transmitter: leader, 32 data bits LSB first, stop burst, then a guard gap.
// Produces a carrier-modulated LED drive and an active-low baseband envelope.
module nec_ir_transmitter #(
   parameter int UNIT_CYCLES  = 28125,
   parameter int LEAD_MARK_U  = 16,
   parameter int LEAD_SPACE_U = 8,
   parameter int ONE_SPACE_U  = 3,
   parameter int GAP_U        = 70,
   parameter int CARRIER_HALF = 658
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic       start,
   input  logic [7:0] address,
   input  logic [7:0] command,
   output logic       IRDA_TXD,
   output logic       ENVELOPE_N,
   output logic       busy,
   output logic       done,
   output logic [2:0] fsm_state
);

   function automatic int max_units();
      int m;
      m = 1;
      if (LEAD_MARK_U > m)  m = LEAD_MARK_U;
      if (LEAD_SPACE_U > m) m = LEAD_SPACE_U;
      if (ONE_SPACE_U > m)  m = ONE_SPACE_U;
      if (GAP_U > m)        m = GAP_U;
      return m;
   endfunction

   localparam int MAX_U = max_units();
   localparam int UW    = $clog2(MAX_U + 1);
   localparam int CW    = $clog2(UNIT_CYCLES + 1);
   localparam int KW    = $clog2(CARRIER_HALF + 1);

   localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);
   localparam logic [KW-1:0] CAR_LAST = KW'(CARRIER_HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LEAD_MARK  = 3'd1,
      S_LEAD_SPACE = 3'd2,
      S_BIT_MARK   = 3'd3,
      S_BIT_SPACE  = 3'd4,
      S_STOP_MARK  = 3'd5,
      S_GAP        = 3'd6
   } state_t;

   state_t         state;
   logic [CW-1:0]  cyc_cnt;
   logic [UW-1:0]  unit_cnt;
   logic [KW-1:0]  car_cnt;
   logic [5:0]     bit_cnt;
   logic [31:0]    shreg;

   logic [UW-1:0]  unit_len;
   logic           unit_end;
   logic           state_end;
   logic           in_mark;

   // Length of the current state in NEC units; a bit space depends on the bit being sent.
   always_comb begin
      unit_len = UW'(1);
      case (state)
         S_LEAD_MARK:  unit_len = UW'(LEAD_MARK_U);
         S_LEAD_SPACE: unit_len = UW'(LEAD_SPACE_U);
         S_BIT_MARK:   unit_len = UW'(1);
         S_BIT_SPACE:  unit_len = shreg[0] ? UW'(ONE_SPACE_U) : UW'(1);
         S_STOP_MARK:  unit_len = UW'(1);
         S_GAP:        unit_len = UW'(GAP_U);
         default:      unit_len = UW'(1);
      endcase
   end

   always_comb begin
      unit_end  = (cyc_cnt == CYC_LAST);
      state_end = unit_end && (unit_cnt == unit_len - UW'(1));
      in_mark   = (state == S_LEAD_MARK) || (state == S_BIT_MARK) ||
                  (state == S_STOP_MARK);
   end

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         state      <= S_IDLE;
         cyc_cnt    <= '0;
         unit_cnt   <= '0;
         car_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         IRDA_TXD   <= 1'b0;
         ENVELOPE_N <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == S_IDLE) begin
            cyc_cnt  <= '0;
            unit_cnt <= '0;
            car_cnt  <= '0;
            if (start) begin
               state      <= S_LEAD_MARK;
               shreg      <= {~command, command, ~address, address};
               bit_cnt    <= '0;
               busy       <= 1'b1;
               ENVELOPE_N <= 1'b0;
               IRDA_TXD   <= 1'b1;
            end
         end else if (state_end) begin
            // Every state boundary restarts the timing counters and the carrier phase.
            cyc_cnt  <= '0;
            unit_cnt <= '0;
            car_cnt  <= '0;
            case (state)
               S_LEAD_MARK: begin
                  state      <= S_LEAD_SPACE;
                  ENVELOPE_N <= 1'b1;
                  IRDA_TXD   <= 1'b0;
               end
               S_LEAD_SPACE: begin
                  state      <= S_BIT_MARK;
                  ENVELOPE_N <= 1'b0;
                  IRDA_TXD   <= 1'b1;
               end
               S_BIT_MARK: begin
                  state      <= S_BIT_SPACE;
                  ENVELOPE_N <= 1'b1;
                  IRDA_TXD   <= 1'b0;
               end
               S_BIT_SPACE: begin
                  shreg      <= shreg >> 1;
                  bit_cnt    <= bit_cnt + 6'd1;
                  ENVELOPE_N <= 1'b0;
                  IRDA_TXD   <= 1'b1;
                  state      <= (bit_cnt == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
               end
               S_STOP_MARK: begin
                  state      <= S_GAP;
                  ENVELOPE_N <= 1'b1;
                  IRDA_TXD   <= 1'b0;
                  done       <= 1'b1;
               end
               S_GAP: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state      <= S_IDLE;
                  busy       <= 1'b0;
                  ENVELOPE_N <= 1'b1;
                  IRDA_TXD   <= 1'b0;
               end
            endcase
         end else begin
            if (unit_end) begin
               cyc_cnt  <= '0;
               unit_cnt <= unit_cnt + UW'(1);
            end else begin
               cyc_cnt <= cyc_cnt + CW'(1);
            end
            if (in_mark) begin
               if (car_cnt == CAR_LAST) begin
                  car_cnt  <= '0;
                  IRDA_TXD <= ~IRDA_TXD;
               end else begin
                  car_cnt <= car_cnt + KW'(1);
               end
            end
         end
      end
   end

   assign fsm_state = state;

endmodule
